// File: rtl/sync_fifo.sv
// Single-clock FIFO: 2^M x N register array with wrap-bit binary pointers,
// registered read data, full/empty/count flags and one-cycle error pulses.
module sync_fifo #(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic [N-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [M:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int DEPTH = 1 << M;
  localparam logic [M:0] PTR_ONE = (M+1)'(1);

  logic [N-1:0] r_mem [DEPTH];
  logic [M:0]   r_wr_ptr;
  logic [M:0]   r_rd_ptr;
  logic [N-1:0] r_dout;
  logic         r_overflow;
  logic         r_underflow;

  logic         w_empty;
  logic         w_full;
  logic         w_rd_acc;
  logic         w_wr_acc;

  // Flags come straight from the registered pointers; the wrap bit
  // distinguishes a full array from an empty one.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[M-1:0] == r_rd_ptr[M-1:0]) &&
                    (r_wr_ptr[M] != r_rd_ptr[M]);
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

  // Storage is data only: never reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[M-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_dout   <= r_mem[r_rd_ptr[M-1:0]];
      end
      r_overflow  <= wr_en && w_full && !w_rd_acc;
      r_underflow <= rd_en && w_empty;
    end
  end

  assign dout      = r_dout;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_wr_ptr - r_rd_ptr;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model predicts each
// cycle's outputs; an independent monitor pops and compares after every edge.
module tb_sync_fifo;

  localparam int N = 8;
  localparam int M = 3;
  localparam int DEPTH = 1 << M;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [N-1:0] dout;
  logic         full;
  logic         empty;
  logic [M:0]   count;
  logic         overflow;
  logic         underflow;

  sync_fifo #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout;
    int count;
    int full;
    int empty;
    int ovf;
    int udf;
  } exp_t;

  exp_t scb[$];
  int   model_q[$];
  int   model_dout = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO semantics with a plain queue, one call per clock.
  task automatic cycle(input bit w, input bit r, input int d);
    exp_t e;
    bit   mfull, mempty, rd_ok, wr_ok;
    mfull  = (model_q.size() == DEPTH);
    mempty = (model_q.size() == 0);
    rd_ok  = r && !mempty;
    wr_ok  = w && (!mfull || rd_ok);
    e.ovf  = int'(w && mfull && !rd_ok);
    e.udf  = int'(r && mempty);
    if (rd_ok) model_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(d & 8'hFF);
    e.dout  = model_dout;
    e.count = model_q.size();
    e.full  = int'(model_q.size() == DEPTH);
    e.empty = int'(model_q.size() == 0);
    scb.push_back(e);
    wr_en = w;
    rd_en = r;
    din   = N'(d);
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_dout = 0;
  endtask

  // Monitor: one expectation per clock edge, compared 1 time unit later.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (scb.size() > 0) begin
      e = scb.pop_front();
      chk("dout",      int'(dout),      e.dout);
      chk("count",     int'(count),     e.count);
      chk("full",      int'(full),      e.full);
      chk("empty",     int'(empty),     e.empty);
      chk("overflow",  int'(overflow),  e.ovf);
      chk("underflow", int'(underflow), e.udf);
    end
  end

  initial begin
    // Asynchronous reset with no clock edge in between.
    #1 rst = 1'b1;
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    chk("rst_count", int'(count), 0);
    chk("rst_dout",  int'(dout),  0);
    model_reset();
    #15 rst = 1'b0;
    repeat (3) cycle(0, 0, 0);

    // Fill past capacity.
    for (int i = 0; i < 10; i++) cycle(1, 0, i);
    // Drain plus one extra read.
    for (int i = 0; i < 9; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);

    // Wrap-around.
    for (int i = 0; i < 5; i++) cycle(1, 0, 16 + i);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 'hA0 + i);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0);

    // Simultaneous read/write when full.
    for (int i = 0; i < 8; i++) cycle(1, 0, 'hC0 + i);
    cycle(1, 1, 'h55);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0);
    // Simultaneous read/write when empty.
    cycle(1, 1, 'h33);
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    // Reset mid-operation, between clock edges.
    for (int i = 0; i < 4; i++) cycle(1, 0, 'h60 + i);
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_dout",  int'(dout),  0);
    model_reset();
    rst = 1'b0;
    cycle(1, 0, 'h77);
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 600; i++) begin
      bit w, r;
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      cycle(w, r, int'($urandom_range(0, 255)));
    end
    cycle(0, 0, 0);
    #10;

    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock synchronous FIFO buffering N-bit words between a producer and a consumer in the same clock domain. Storage is a 2^M-entry register array addressed by binary read/write pointers with an extra wrap bit. Provides full/empty flags, an occupancy count and one-cycle overflow/underflow error pulses. Used as a rate-smoothing buffer for bursty writers feeding a slower, continuous reader.

Parameters:
N, 8, data word width in bits
M, 3, address width; depth DEPTH = 2^M (default 8 entries)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous active-high reset
din  input  N  write data
wr_en  input  1  write request
rd_en  input  1  read request
dout  output  N  registered read data
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  M+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write requested while full and not accepted
underflow  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (rst=1, immediately, no clock required): wr_ptr=0, rd_ptr=0, count=0, dout=0, empty=1, full=0, overflow=0, underflow=0. Array contents are not cleared and need no defined value.
- Pointers are M+1 bits. Array index = low M bits. Pointers increment modulo 2^(M+1) and wrap naturally.
- empty = (wr_ptr == rd_ptr). full = (low M bits equal) AND (MSBs differ). Both derive combinationally from the registered pointers, so they update in the same cycle as the pointer change.
- count = wr_ptr - rd_ptr, modulo 2^(M+1).
- Write accept: wr_en=1 AND (full=0 OR read accepted in the same cycle). Accepted: mem[wr_ptr]<=din; wr_ptr++.
- Read accept: rd_en=1 AND empty=0. Accepted: dout<=mem[rd_ptr]; rd_ptr++. Latency: data appears on dout one cycle after the accepting edge. dout holds its last value when no read is accepted.
- Simultaneous write and read:
  - When full: both are accepted. count stays DEPTH; full stays 1.
  - When empty: only the write is accepted. The read is rejected (no fall-through) and underflow pulses. count becomes 1.
  - Otherwise: both are accepted and count is unchanged.
- overflow <= wr_en & full & ~(read accepted). underflow <= rd_en & empty. Both are registered, high for exactly one cycle per offending request, and cause no state change. Rejected data is dropped.
- Asserting rst in the middle of operation discards all contents: the FIFO returns to empty, and dout reads 0 until the next accepted read.
- Ordering is strictly first-in first-out across pointer wrap-around.

Test Plan:
- Reset: assert rst without any clock edge. Required: empty=1, full=0, count=0, dout=0. Deassert rst, hold wr_en=rd_en=0 for 3 cycles. Required: all outputs unchanged.
- Fill and overflow: rd_en=0, write din=0..9 on consecutive cycles. Required: count steps 1..8 and full=1 after the 8th write. overflow pulses on the cycles that write 8 and 9. count stays 8.
- Drain and underflow: after the fill, rd_en=1 for 9 cycles. Required: dout=0..7 in order, each one cycle after its read; empty=1 after the 8th read. underflow pulses once on the 9th read, and dout stays 7.
- Wrap-around: write 5 words, read 5, then write 0xA0..0xA7 and read them all back. Required: output is 0xA0..0xA7 in order, full asserts exactly at count 8, and no error pulses occur.
- Simultaneous read and write:
  - FIFO full with 8 entries, wr_en=rd_en=1, din=0x55. Required: oldest word out, count=8, full=1, overflow=0.
  - FIFO empty, wr_en=rd_en=1, din=0x33. Required: count=1, underflow=1, and the next read returns 0x33.
- Reset mid-operation: with 4 entries stored, pulse rst between clock edges. Required: empty=1 and count=0 immediately. The next write/read pair returns the newly written data.
